rgb_channel_ctrl: RTL and testbench
===================================

RGB_CHANNEL_CTRL -- requirements
Module: rgb_channel_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles required before the debounced button level changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning idle cycles in EDIT before automatic return to IDLE.
REQ-003 SHALL have parameter STEP, default 1, meaning the amount added or subtracted per encoder step (1..255).
REQ-004 clk  input  1  sole clock; all state is updated on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 a  input  1  raw quadrature phase A, asynchronous to clk.
REQ-007 b  input  1  raw quadrature phase B, asynchronous to clk.
REQ-008 btn  input  1  raw push button, active-high, asynchronous, bouncing.
REQ-009 red, green, blue  output  8 each  registered channel values.
REQ-010 sel  output  2  channel being edited: 0=red, 1=green, 2=blue; 3 is never driven.
REQ-011 editing  output  1  high exactly while the FSM is in EDIT.

Function
REQ-012 a, b and btn SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 The synchronized A SHALL be registered once more (a_prev); a step SHALL be decoded only on an A edge: up = (A rise and B=0) or (A fall and B=1); down = (A rise and B=1) or (A fall and B=0).
REQ-014 A channel register SHALL change on the 3rd rising clk edge after the a transition is first sampled (3-cycle pin-to-output latency).
REQ-015 The debounced button level SHALL change only after the synchronized btn differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-016 A press event SHALL be a single-cycle pulse on the 0->1 transition of the debounced level; release SHALL generate no event.
REQ-017 FSM states SHALL be IDLE and EDIT; reset state IDLE.
REQ-018 IDLE: steps SHALL be ignored; a press SHALL go to EDIT with sel=0.
REQ-019 EDIT: a press SHALL advance sel 0->1->2; a press with sel=2 SHALL go to IDLE with sel=0.
REQ-020 EDIT: an up or down step SHALL add or subtract STEP on the selected channel, computed 9-bit and saturated to 255 or 0 (no wrap-around).
REQ-021 EDIT: a timeout counter SHALL clear on every step or press and on entry; on reaching TIMEOUT_CYCLES-1 with no event, the FSM SHALL go to IDLE with sel=0.
REQ-022 A step and a press in the same cycle SHALL both apply: the step hits the channel selected before the press, then sel/state advance.
REQ-023 A timeout coinciding with a step or press SHALL be ignored (the event wins).
REQ-024 Unselected channels SHALL hold their value in every cycle.

Reset
REQ-025 reset_n low SHALL immediately clear red/green/blue to 0, sel to 0, editing to 0, state to IDLE, and clear all synchronizer, debounce, timeout and a_prev flops.
REQ-026 Reset asserted mid-step or mid-debounce SHALL discard the pending event; deassertion is synchronized externally to clk.

Structure
REQ-027 A shared package rgb_pkg SHALL hold the state encoding (ST_IDLE, ST_EDIT), channel indices (CH_RED=0, CH_GREEN=1, CH_BLUE=2) and channel width (8).
REQ-028 The button synchronizer plus debouncer plus press pulse SHALL be one sub-module, btn_debounce, parameterised by DEBOUNCE_CYCLES.
REQ-029 The encoder decode, FSM, timeout counter and channel registers SHALL reside in rgb_channel_ctrl.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, STEP=1)
REQ-030 Reset, then 5 up-steps with no press -> red=green=blue=0, editing=0.
REQ-031 Clean press, then 3 up-steps -> editing=1, sel=0, red=3; second press, then 2 down-steps -> sel=1, green=0 (saturated), red=3.
REQ-032 Press bouncing 0/1 every 2 cycles for 20 cycles, then held -> exactly one press event; release bounce -> no event.
REQ-033 In EDIT with blue=254, 3 up-steps -> blue=255; third press from sel=2 -> IDLE, sel=0.
REQ-034 Enter EDIT, no activity for 50 cycles -> editing=0 on cycle 50; a step on cycle 49 restarts the count.
REQ-035 Step and press in the same cycle with sel=0, red=7 -> red=8, sel=1; reset_n pulsed low mid-EDIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB channel controller: FSM states,
// channel indices, channel width and the saturating step function.
package rgb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  localparam int CH_W = 8;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH_RED   = 2'd0;
  localparam ch_idx_t CH_GREEN = 2'd1;
  localparam ch_idx_t CH_BLUE  = 2'd2;

  // The carry or borrow out of the 9-bit result selects the clamp value.
  function automatic logic [CH_W-1:0] sat_step(input logic [CH_W-1:0] val,
                                               input logic            up,
                                               input logic [CH_W-1:0] step);
    logic [CH_W:0] res;
    if (up) begin
      res = {1'b0, val} + {1'b0, step};
      return res[CH_W] ? {CH_W{1'b1}} : res[CH_W-1:0];
    end
    res = {1'b0, val} - {1'b0, step};
    return res[CH_W] ? {CH_W{1'b0}} : res[CH_W-1:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle press pulse on the
// 0->1 transition of the debounced level. Release produces no pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          press <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rgb_channel_ctrl.sv
// Rotary-encoder RGB editor: quadrature decode, IDLE/EDIT FSM with
// inactivity timeout, and three saturating 8-bit channel registers.
module rgb_channel_ctrl
  import rgb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int STEP            = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a,
  input  logic            b,
  input  logic            btn,
  output logic [CH_W-1:0] red,
  output logic [CH_W-1:0] green,
  output logic [CH_W-1:0] blue,
  output logic [1:0]      sel,
  output logic            editing
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    a_sync, b_sync;
  logic          a_prev;
  logic          a_edge, step_up, step_dn, step_any;
  logic          press;
  state_t        state, state_nx;
  ch_idx_t       sel_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic          ch_we;
  logic [CH_W-1:0] ch_cur, ch_new;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn),
    .press   (press)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sync <= '0;
      b_sync <= '0;
      a_prev <= 1'b0;
    end else begin
      a_sync <= {a_sync[0], a};
      b_sync <= {b_sync[0], b};
      a_prev <= a_sync[1];
    end
  end

  // On an A edge, A != B means clockwise (up), A == B means down.
  assign a_edge   = a_sync[1] ^ a_prev;
  assign step_up  = a_edge & (a_sync[1] ^ b_sync[1]);
  assign step_dn  = a_edge & ~(a_sync[1] ^ b_sync[1]);
  assign step_any = step_up | step_dn;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    tmo_nx   = tmo + 1'b1;
    ch_we    = 1'b0;
    if (state == ST_IDLE) begin
      tmo_nx = '0;
      if (press) begin
        state_nx = ST_EDIT;
        sel_nx   = CH_RED;
      end
    end else begin
      ch_we = step_any;
      if (press) begin
        tmo_nx = '0;
        if (sel == CH_BLUE) begin
          state_nx = ST_IDLE;
          sel_nx   = CH_RED;
        end else begin
          sel_nx = sel + 2'd1;
        end
      end else if (step_any) begin
        tmo_nx = '0;
      end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state_nx = ST_IDLE;
        sel_nx   = CH_RED;
        tmo_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      sel   <= CH_RED;
      tmo   <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      tmo   <= tmo_nx;
    end
  end

  assign editing = (state == ST_EDIT);

  // The step always targets the channel selected before any same-cycle press.
  always_comb begin
    ch_cur = red;
    if (sel == CH_GREEN) ch_cur = green;
    if (sel == CH_BLUE)  ch_cur = blue;
  end

  assign ch_new = sat_step(ch_cur, step_up, CH_W'(STEP));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (ch_we) begin
      case (sel)
        CH_RED:   red   <= ch_new;
        CH_GREEN: green <= ch_new;
        CH_BLUE:  blue  <= ch_new;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_channel_ctrl.sv
// Directed self-checking bench for rgb_channel_ctrl with
// DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, STEP=1.
module tb_rgb_channel_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a, b, btn;
  logic [7:0] red, green, blue;
  logic [1:0] sel;
  logic       editing;

  int checks = 0;
  int errors = 0;
  int lat    = 7;

  rgb_channel_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (50),
    .STEP            (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .btn     (btn),
    .red     (red),
    .green   (green),
    .blue    (blue),
    .sel     (sel),
    .editing (editing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One encoder detent: toggle A with B chosen for the wanted direction.
  task automatic step(input logic up);
    b = up ? a : ~a;
    a = ~a;
    tick(5);
  endtask

  task automatic press_clean();
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(10);
  endtask

  // Raise btn and count edges until editing rises; leaves sim just after that edge.
  task automatic press_detect(output int n);
    n = 0;
    btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      n++;
      if (editing) break;
    end
    btn = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    a = 1'b0; b = 1'b0; btn = 1'b0;
    tick(3);
    check("rst_red", red, 0);
    check("rst_green", green, 0);
    check("rst_blue", blue, 0);
    check("rst_sel", sel, 0);
    check("rst_editing", editing, 0);
    reset_n = 1'b1;
    tick(2);

    // Steps in IDLE are ignored.
    for (int i = 0; i < 5; i++) step(1'b1);
    check("idle_red", red, 0);
    check("idle_green", green, 0);
    check("idle_blue", blue, 0);
    check("idle_editing", editing, 0);

    press_clean();
    check("p1_editing", editing, 1);
    check("p1_sel", sel, 0);

    // First up-step: channel changes on the 3rd edge after A is sampled.
    b = a; a = ~a;
    tick(2);
    check("lat_edge2_red", red, 0);
    tick(1);
    check("lat_edge3_red", red, 1);
    tick(2);
    step(1'b1);
    step(1'b1);
    check("up3_red", red, 3);

    press_clean();
    check("p2_sel", sel, 1);
    step(1'b0);
    step(1'b0);
    check("dn_sat_green", green, 0);
    check("dn_red_hold", red, 3);

    // Bouncing press: pulses shorter than the debounce window.
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      tick(2);
    end
    check("bounce_no_early", sel, 1);
    btn = 1'b1;
    tick(12);
    check("bounce_one_press", sel, 2);
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 1);
      tick(2);
    end
    btn = 1'b0;
    tick(8);
    check("release_no_event", sel, 2);
    check("release_editing", editing, 1);

    for (int i = 0; i < 254; i++) step(1'b1);
    check("blue_254", blue, 254);
    for (int i = 0; i < 3; i++) step(1'b1);
    check("blue_sat_255", blue, 255);
    press_clean();
    check("p3_idle", editing, 0);
    check("p3_sel", sel, 0);
    check("p3_red_hold", red, 3);
    check("p3_green_hold", green, 0);

    // Timeout: editing falls exactly 50 edges after entry.
    press_detect(lat);
    check("enter_editing", editing, 1);
    check("press_latency", lat, 7);
    tick(49);
    check("tmo_49_editing", editing, 1);
    tick(1);
    check("tmo_50_editing", editing, 0);
    check("tmo_sel", sel, 0);

    // Step landing on the timeout cycle wins and restarts the count.
    press_detect(lat);
    tick(47);
    b = a; a = ~a;
    tick(3);
    check("tmo_step_wins", editing, 1);
    check("tmo_step_red", red, 4);
    tick(49);
    check("tmo_restart_49", editing, 1);
    tick(1);
    check("tmo_restart_50", editing, 0);

    // Step and press in the same cycle.
    press_detect(lat);
    for (int i = 0; i < 3; i++) step(1'b1);
    check("pre_both_red", red, 7);
    btn = 1'b1;
    tick(lat - 3);
    b = a; a = ~a;
    tick(3);
    check("both_red", red, 8);
    check("both_sel", sel, 1);
    check("both_green", green, 0);
    btn = 1'b0;
    tick(2);

    // Asynchronous reset mid-EDIT, checked before any clock edge.
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_red", red, 0);
    check("arst_green", green, 0);
    check("arst_blue", blue, 0);
    check("arst_sel", sel, 0);
    check("arst_editing", editing, 0);
    #2;
    reset_n = 1'b1;
    tick(10);
    check("post_rst_editing", editing, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
